// File: rtl/sample_record_writer.sv
// Sampling-record writer: turns changes on the sampling-action bus into tagged records
// and queues them in a small FIFO that drains over a valid/ready handshake.
module sample_record_writer #(
   parameter int DATA_W     = 64,
   parameter int NUM_CH     = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int TEST_LO    = 3,
   parameter int TEST_HI    = 180
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            test_mode,
   input  logic [NUM_CH-1:0]               sampling_actions,
   input  logic [DATA_W-1:0]               calc_values,
   output logic                            wr_valid,
   input  logic                            wr_ready,
   output logic [DATA_W-1:0]               wr_data,
   output logic [NUM_CH-1:0]               wr_tag,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [15:0]                     overflow_cnt
);

   localparam int HALF_W = DATA_W / 2;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int REC_W  = NUM_CH + DATA_W;

   logic [NUM_CH-1:0] last_actions_reg;
   logic [HALF_W-1:0] cnt_up_reg;
   logic [HALF_W-1:0] cnt_dn_reg;
   logic [HALF_W-1:0] cnt_up_next;
   logic [HALF_W-1:0] cnt_dn_next;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [LVL_W-1:0]  level_reg;
   logic [15:0]       overflow_reg;
   logic [REC_W-1:0]  mem [FIFO_DEPTH];
   logic [REC_W-1:0]  head_rec;

   logic              action_change;
   logic              event_hit;
   logic              one_hot;
   logic              fifo_full;
   logic              push;
   logic              pop;
   logic              drop;
   logic [DATA_W-1:0] payload;

   always_comb begin
      action_change = enable && (sampling_actions != last_actions_reg);
      event_hit     = action_change && (sampling_actions != '0);
      one_hot       = (sampling_actions != '0) &&
                      ((sampling_actions & (sampling_actions - NUM_CH'(1))) == '0);

      cnt_up_next = cnt_up_reg;
      cnt_dn_next = cnt_dn_reg;
      if (event_hit && one_hot) begin
         if (cnt_up_reg == HALF_W'(TEST_HI)) begin
            cnt_up_next = HALF_W'(TEST_LO);
            cnt_dn_next = HALF_W'(TEST_HI);
         end else begin
            cnt_up_next = cnt_up_reg + HALF_W'(1);
            cnt_dn_next = cnt_dn_reg - HALF_W'(1);
         end
      end

      // The record carries the post-update counter values of its own event.
      payload   = test_mode ? {cnt_dn_next, cnt_up_next} : calc_values;
      fifo_full = (level_reg == LVL_W'(FIFO_DEPTH));
      pop       = wr_valid && wr_ready;
      push      = event_hit && (!fifo_full || pop);
      drop      = event_hit && fifo_full && !pop;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_actions_reg <= '1;
         cnt_up_reg       <= HALF_W'(TEST_LO);
         cnt_dn_reg       <= HALF_W'(TEST_HI);
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         level_reg        <= '0;
         overflow_reg     <= '0;
      end else begin
         if (!enable) begin
            last_actions_reg <= '1;
         end else if (action_change) begin
            last_actions_reg <= sampling_actions;
         end
         cnt_up_reg <= cnt_up_next;
         cnt_dn_reg <= cnt_dn_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase
         if (drop && (overflow_reg != 16'hFFFF)) begin
            overflow_reg <= overflow_reg + 16'd1;
         end
      end
   end

   // Storage needs no reset: level_reg alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {sampling_actions, payload};
      end
   end

   assign head_rec     = mem[rd_ptr_reg];
   assign wr_valid     = (level_reg != '0);
   assign wr_data      = wr_valid ? head_rec[DATA_W-1:0] : '0;
   assign wr_tag       = wr_valid ? head_rec[REC_W-1:DATA_W] : '0;
   assign fifo_level   = level_reg;
   assign overflow_cnt = overflow_reg;

endmodule

// File: tb/tb_sample_record_writer.sv
// Self-checking bench for sample_record_writer: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_sample_record_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        test_mode;
   logic [1:0]  sampling_actions;
   logic [63:0] calc_values;
   logic        wr_valid;
   logic        wr_ready;
   logic [63:0] wr_data;
   logic [1:0]  wr_tag;
   logic [3:0]  fifo_level;
   logic [15:0] overflow_cnt;

   int tests = 0;
   int fails = 0;

   sample_record_writer dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .test_mode        (test_mode),
      .sampling_actions (sampling_actions),
      .calc_values      (calc_values),
      .wr_valid         (wr_valid),
      .wr_ready         (wr_ready),
      .wr_data          (wr_data),
      .wr_tag           (wr_tag),
      .fifo_level       (fifo_level),
      .overflow_cnt     (overflow_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          en;
      bit          tm;
      logic [1:0]  act;
      logic [63:0] calc;
      bit          rdy;
      bit          exp_valid;
      logic [1:0]  exp_tag;
      logic [63:0] exp_data;
      int          exp_level;
      int          exp_ovf;
   } vec_t;

   typedef struct {
      logic [1:0]  tag;
      logic [63:0] data;
   } rec_t;

   // reference model state
   rec_t m_q[$];
   int   m_last;
   int   m_up;
   int   m_dn;
   int   m_ovf;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input bit ev, input logic [1:0] et,
                            input logic [63:0] ed, input int el, input int eo);
      check({name, ".valid"}, 64'(wr_valid), 64'(ev));
      check({name, ".level"}, 64'(fifo_level), 64'(el));
      check({name, ".ovf"}, 64'(overflow_cnt), 64'(eo));
      if (ev) begin
         check({name, ".tag"}, 64'(wr_tag), 64'(et));
         check({name, ".data"}, wr_data, ed);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      enable           = 1'b0;
      test_mode        = 1'b0;
      sampling_actions = 2'b00;
      calc_values      = 64'd0;
      wr_ready         = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;
      m_q.delete();
      m_last = 3;
      m_up   = 3;
      m_dn   = 180;
      m_ovf  = 0;
   endtask

   function automatic logic [63:0] tp(input int up, input int dn);
      logic [31:0] u;
      logic [31:0] d;
      u = 32'(up);
      d = 32'(dn);
      return {d, u};
   endfunction

   // One clock of the reference model, using the inputs presented at that edge.
   task automatic model_step();
      bit   pop;
      bit   ev;
      rec_t r;
      pop = (m_q.size() > 0) && wr_ready;
      ev  = 1'b0;
      if (!enable) begin
         m_last = 3;
      end else if (int'(sampling_actions) != m_last) begin
         m_last = int'(sampling_actions);
         ev     = (sampling_actions != 2'b00);
      end
      if (ev && $countones(sampling_actions) == 1) begin
         if (m_up == 180) begin
            m_up = 3;
            m_dn = 180;
         end else begin
            m_up = m_up + 1;
            m_dn = m_dn - 1;
         end
      end
      if (pop) void'(m_q.pop_front());
      if (ev) begin
         r.tag  = sampling_actions;
         r.data = test_mode ? tp(m_up, m_dn) : calc_values;
         if (m_q.size() < 8) m_q.push_back(r);
         else if (m_ovf < 65535) m_ovf = m_ovf + 1;
      end
   endtask

   vec_t vecs[8];

   initial begin
      int up;
      int dn;
      logic [1:0] t;

      vecs[0] = '{1, 1, 2'b00, 64'd0, 0, 0, 2'b00, 64'd0, 0, 0};
      vecs[1] = '{1, 1, 2'b01, 64'd0, 0, 1, 2'b01, tp(4, 179), 1, 0};
      vecs[2] = '{1, 1, 2'b01, 64'd0, 0, 1, 2'b01, tp(4, 179), 1, 0};
      vecs[3] = '{1, 1, 2'b01, 64'd0, 1, 0, 2'b00, 64'd0, 0, 0};
      vecs[4] = '{1, 0, 2'b11, 64'hDEAD_BEEF_0123_4567, 0, 1, 2'b11, 64'hDEAD_BEEF_0123_4567, 1, 0};
      vecs[5] = '{1, 1, 2'b10, 64'd0, 0, 1, 2'b11, 64'hDEAD_BEEF_0123_4567, 2, 0};
      vecs[6] = '{1, 1, 2'b10, 64'd0, 1, 1, 2'b10, tp(5, 178), 1, 0};
      vecs[7] = '{1, 1, 2'b10, 64'd0, 1, 0, 2'b00, 64'd0, 0, 0};

      // Reset state, checked while reset is held and before any clock edge.
      reset = 1'b1;
      enable = 1'b0; test_mode = 1'b0; sampling_actions = 2'b00;
      calc_values = 64'd0; wr_ready = 1'b0;
      #2;
      check_out("reset", 1'b0, 2'b00, 64'd0, 0, 0);
      check("reset.data", wr_data, 64'd0);
      check("reset.tag", 64'(wr_tag), 64'd0);

      // Vector table: first record, non-one-hot calc record, ordered drain.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         enable = vecs[i].en; test_mode = vecs[i].tm; sampling_actions = vecs[i].act;
         calc_values = vecs[i].calc; wr_ready = vecs[i].rdy;
         cycle();
         check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_tag,
                   vecs[i].exp_data, vecs[i].exp_level, vecs[i].exp_ovf);
         $display("[TB] vector %0d applied act=%b rdy=%0d", i, vecs[i].act, vecs[i].rdy);
      end

      // Counter wrap over 178 alternating one-hot events, draining every cycle.
      do_reset();
      enable = 1'b1; test_mode = 1'b1; wr_ready = 1'b1;
      up = 3; dn = 180;
      for (int k = 1; k <= 178; k++) begin
         sampling_actions = (k % 2 == 1) ? 2'b01 : 2'b10;
         if (up == 180) begin up = 3; dn = 180; end
         else begin up++; dn--; end
         cycle();
         check_out($sformatf("wrap%0d", k), 1'b1, sampling_actions, tp(up, dn), 1, 0);
      end
      $display("[TB] wrap sequence: last record up=%0d dn=%0d", up, dn);

      // Overflow: 10 events with no drain, then full + pop + event, then ordered drain.
      do_reset();
      enable = 1'b1; test_mode = 1'b1; wr_ready = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         sampling_actions = (k % 2 == 1) ? 2'b01 : 2'b10;
         cycle();
      end
      check_out("full", 1'b1, 2'b01, tp(4, 179), 8, 2);
      sampling_actions = 2'b01; wr_ready = 1'b1;
      cycle();
      check_out("full_pop_push", 1'b1, 2'b10, tp(5, 178), 8, 2);
      for (int k = 2; k <= 9; k++) begin
         int r;
         r = (k == 9) ? 11 : k;
         t = (r % 2 == 1) ? 2'b01 : 2'b10;
         check_out($sformatf("drain%0d", r), 1'b1, t, tp(3 + r, 180 - r), 10 - k, 2);
         cycle();
      end
      check_out("drained", 1'b0, 2'b00, 64'd0, 0, 2);
      $display("[TB] overflow sequence done ovf=%0d", overflow_cnt);

      // Enable toggling with a held bus, then asynchronous reset with 3 records queued.
      do_reset();
      test_mode = 1'b1; wr_ready = 1'b0; sampling_actions = 2'b01;
      enable = 1'b1; cycle(); check_out("en1", 1'b1, 2'b01, tp(4, 179), 1, 0);
      cycle();               check_out("hold", 1'b1, 2'b01, tp(4, 179), 1, 0);
      enable = 1'b0; cycle(); check_out("dis", 1'b1, 2'b01, tp(4, 179), 1, 0);
      enable = 1'b1; cycle(); check_out("reen", 1'b1, 2'b01, tp(4, 179), 2, 0);
      cycle();               check_out("reen_hold", 1'b1, 2'b01, tp(4, 179), 2, 0);
      enable = 1'b0; cycle();
      enable = 1'b1; cycle(); check_out("reen2", 1'b1, 2'b01, tp(4, 179), 3, 0);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset.valid", 64'(wr_valid), 64'd0);
      check("async_reset.level", 64'(fifo_level), 64'd0);
      $display("[TB] async reset with 3 queued: valid=%0d level=%0d", wr_valid, fifo_level);
      @(negedge clk);

      // Randomized run against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         enable           = ($urandom_range(0, 9) != 0);
         test_mode        = $urandom_range(0, 1);
         sampling_actions = 2'($urandom_range(0, 3));
         calc_values      = {$urandom, $urandom};
         wr_ready         = ($urandom_range(0, 9) < 3);
         model_step();
         cycle();
         if (m_q.size() > 0)
            check_out($sformatf("rand%0d", c), 1'b1, m_q[0].tag, m_q[0].data, m_q.size(), m_ovf);
         else
            check_out($sformatf("rand%0d", c), 1'b0, 2'b00, 64'd0, 0, m_ovf);
      end
      $display("[TB] random run done: level=%0d ovf=%0d", m_q.size(), m_ovf);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
